// File: rtl/dual_input_debounce_if.sv
// rtl/dual_input_debounce_if.sv - raw inputs in, debounced levels and edge pulses out
interface dual_input_debounce_if;
    logic raw0;
    logic raw1;
    logic in0;
    logic in1;
    logic rise0;
    logic fall0;
    logic rise1;
    logic fall1;

    modport slave (
        input  raw0, raw1,
        output in0, in1, rise0, fall0, rise1, fall1
    );

    modport master (
        output raw0, raw1,
        input  in0, in1, rise0, fall0, rise1, fall1
    );
endinterface

// File: rtl/dual_input_debounce.sv
// rtl/dual_input_debounce.sv - two independent synchronize-and-debounce channels
// Each channel: SYNC_STAGES flop chain, equality-compared stability counter, 4-state FSM.
module dual_input_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    dual_input_debounce_if.slave  bus
);
    typedef enum logic [1:0] {
        STABLE_LO,
        WAIT_HI,
        STABLE_HI,
        WAIT_LO
    } state_e;

    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0] raw;
    logic [1:0] lvl;
    logic [1:0] rise;
    logic [1:0] fall;

    assign raw = {bus.raw1, bus.raw0};

    genvar ch;
    generate
        for (ch = 0; ch < 2; ch++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_q;
            logic                   sync;
            state_e                 state_q, state_d;
            logic [CNT_W-1:0]       cnt_q, cnt_d;
            logic                   lvl_q, lvl_d;
            logic                   rise_q, rise_d;
            logic                   fall_q, fall_d;

            // Plain shift chain: nothing between stages so metastability settles undisturbed.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], raw[ch]};
                end
            end

            assign sync = sync_q[SYNC_STAGES-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= STABLE_LO;
                    cnt_q   <= '0;
                    lvl_q   <= 1'b0;
                    rise_q  <= 1'b0;
                    fall_q  <= 1'b0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    lvl_q   <= lvl_d;
                    rise_q  <= rise_d;
                    fall_q  <= fall_d;
                end
            end

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                lvl_d   = lvl_q;
                rise_d  = 1'b0;
                fall_d  = 1'b0;
                unique case (state_q)
                    STABLE_LO: begin
                        if (sync) begin
                            state_d = WAIT_HI;
                            cnt_d   = CNT_ONE;
                        end else begin
                            cnt_d   = '0;
                        end
                    end
                    WAIT_HI: begin
                        if (!sync) begin
                            state_d = STABLE_LO;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_DONE) begin
                            state_d = STABLE_HI;
                            cnt_d   = '0;
                            lvl_d   = 1'b1;
                            rise_d  = 1'b1;
                        end else begin
                            cnt_d   = cnt_q + CNT_ONE;
                        end
                    end
                    STABLE_HI: begin
                        if (!sync) begin
                            state_d = WAIT_LO;
                            cnt_d   = CNT_ONE;
                        end else begin
                            cnt_d   = '0;
                        end
                    end
                    WAIT_LO: begin
                        if (sync) begin
                            state_d = STABLE_HI;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_DONE) begin
                            state_d = STABLE_LO;
                            cnt_d   = '0;
                            lvl_d   = 1'b0;
                            fall_d  = 1'b1;
                        end else begin
                            cnt_d   = cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                    end
                endcase
            end

            assign lvl[ch]  = lvl_q;
            assign rise[ch] = rise_q;
            assign fall[ch] = fall_q;
        end
    endgenerate

    assign bus.in0   = lvl[0];
    assign bus.in1   = lvl[1];
    assign bus.rise0 = rise[0];
    assign bus.fall0 = fall[0];
    assign bus.rise1 = rise[1];
    assign bus.fall1 = fall[1];
endmodule

// File: tb/tb_dual_input_debounce.sv
// tb/tb_dual_input_debounce.sv - scoreboard bench for dual_input_debounce
module tb_dual_input_debounce;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    typedef struct {
        int ch;
        bit rise;
        int cyc;
    } ev_t;

    ev_t sb[$];

    dual_input_debounce_if dut_if ();

    dual_input_debounce #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Clean step sampled first at edge d+1 lands on edge d+1+SYNC_STAGES+DEBOUNCE_CYCLES.
    localparam int LAT = 7;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int ch, input bit rise, input int when);
        ev_t e;
        e.ch   = ch;
        e.rise = rise;
        e.cyc  = when;
        sb.push_back(e);
    endtask

    task automatic lower0();
        int d;
        tick();
        d = cyc;
        dut_if.raw0 = 1'b0;
        push(0, 1'b0, d + LAT);
        wait_to(d + LAT + 2);
    endtask

    always @(negedge clk) begin
        logic [1:0] r;
        logic [1:0] f;
        logic [1:0] l;
        ev_t        e;
        r = {dut_if.rise1, dut_if.rise0};
        f = {dut_if.fall1, dut_if.fall0};
        l = {dut_if.in1, dut_if.in0};
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++;
            fails++;
            $display("FAIL missed_pulse ch%0d rise=%0d: got none expected at cyc %0d", sb[0].ch, sb[0].rise, sb[0].cyc);
            void'(sb.pop_front());
        end
        for (int c = 0; c < 2; c++) begin
            if (r[c] === 1'b1 || f[c] === 1'b1) begin
                checks++;
                if (r[c] === 1'b1 && f[c] === 1'b1) begin
                    fails++;
                    $display("FAIL rise_fall_both ch%0d at cyc %0d: got both expected one", c, cyc);
                end else if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_pulse ch%0d rise=%0d at cyc %0d: got pulse expected none", c, r[c], cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.ch != c || e.rise != r[c] || e.cyc != cyc || l[c] !== r[c]) begin
                        fails++;
                        $display("FAIL pulse_event: got ch%0d rise=%0d lvl=%0d cyc %0d expected ch%0d rise=%0d lvl=%0d cyc %0d",
                                 c, r[c], l[c], cyc, e.ch, e.rise, e.rise, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        int d;
        rst         = 1'b1;
        dut_if.raw0 = 1'b1;
        dut_if.raw1 = 1'b1;

        // Reset with both raw inputs high
        repeat (3) begin
            tick();
            chk("reset_outputs", {2'b00, dut_if.in0, dut_if.in1, dut_if.rise0, dut_if.fall0,
                                  dut_if.rise1, dut_if.fall1}, 8'h00);
        end
        rst = 1'b0;
        d   = cyc;
        push(0, 1'b1, d + LAT);
        push(1, 1'b1, d + LAT);
        wait_to(d + LAT - 1);
        chk("post_reset_in_before", {6'd0, dut_if.in1, dut_if.in0}, 8'h00);
        wait_to(d + LAT);
        chk("post_reset_in_after", {6'd0, dut_if.in1, dut_if.in0}, 8'h03);
        wait_to(d + LAT + 2);

        // Falling edge on channel 1
        tick();
        d = cyc;
        dut_if.raw1 = 1'b0;
        push(1, 1'b0, d + LAT);
        wait_to(d + LAT - 1);
        chk("fall_in1_before", {7'd0, dut_if.in1}, 8'h01);
        wait_to(d + LAT + 2);
        chk("fall_in1_after", {7'd0, dut_if.in1}, 8'h00);
        chk("fall_in0_kept", {7'd0, dut_if.in0}, 8'h01);

        lower0();

        // Clean step on channel 0
        tick();
        d = cyc;
        dut_if.raw0 = 1'b1;
        push(0, 1'b1, d + LAT);
        wait_to(d + LAT - 1);
        chk("step_in0_before", {7'd0, dut_if.in0}, 8'h00);
        wait_to(d + LAT);
        chk("step_in0_after", {7'd0, dut_if.in0}, 8'h01);
        wait_to(d + LAT + 2);
        chk("step_in1_quiet", {7'd0, dut_if.in1}, 8'h00);

        lower0();

        // Bounce: 3 high / 1 low, five times, then steady high
        repeat (5) begin
            tick();
            dut_if.raw0 = 1'b1;
            tick();
            tick();
            tick();
            dut_if.raw0 = 1'b0;
        end
        tick();
        chk("bounce_in0_held", {7'd0, dut_if.in0}, 8'h00);
        d = cyc;
        dut_if.raw0 = 1'b1;
        push(0, 1'b1, d + LAT);
        wait_to(d + LAT - 1);
        chk("bounce_in0_before", {7'd0, dut_if.in0}, 8'h00);
        wait_to(d + LAT + 2);
        chk("bounce_in0_after", {7'd0, dut_if.in0}, 8'h01);

        lower0();

        // Reset during qualification
        tick();
        d = cyc;
        dut_if.raw0 = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        d = cyc;
        push(0, 1'b1, d + LAT);
        wait_to(d + LAT - 1);
        chk("midrst_in0_before", {7'd0, dut_if.in0}, 8'h00);
        wait_to(d + LAT + 2);
        chk("midrst_in0_after", {7'd0, dut_if.in0}, 8'h01);

        lower0();

        // Simultaneous rise, then channel 1 falls; AND of the two levels
        tick();
        d = cyc;
        dut_if.raw0 = 1'b1;
        dut_if.raw1 = 1'b1;
        push(0, 1'b1, d + LAT);
        push(1, 1'b1, d + LAT);
        wait_to(d + LAT - 1);
        chk("and_before_rise", {7'd0, dut_if.in0 & dut_if.in1}, 8'h00);
        wait_to(d + LAT);
        chk("and_after_rise", {7'd0, dut_if.in0 & dut_if.in1}, 8'h01);
        wait_to(d + LAT + 2);

        tick();
        d = cyc;
        dut_if.raw1 = 1'b0;
        push(1, 1'b0, d + LAT);
        wait_to(d + LAT - 1);
        chk("and_before_fall", {7'd0, dut_if.in0 & dut_if.in1}, 8'h01);
        wait_to(d + LAT);
        chk("and_after_fall", {7'd0, dut_if.in0 & dut_if.in1}, 8'h00);
        chk("and_in0_kept", {7'd0, dut_if.in0}, 8'h01);

        repeat (5) tick();
        chk("scoreboard_drained", 8'(sb.size()), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/dual_input_debounce.md
Name: dual_input_debounce

Overview:
- Conditions two raw, asynchronous, bouncy inputs (switches or buttons) into clean, synchronous levels.
- Its level outputs drive the in0/in1 operands of the downstream two-input AND stage.
- Each channel has an independent synchronizer, a stability counter and a 4-state FSM.
- Each channel also emits single-cycle rise/fall pulses for event logic.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the per-channel synchronizer; legal range 2..4.
- DEBOUNCE_CYCLES, 50000, consecutive sampled cycles at a new level required to accept it; legal minimum 2.
- CNT_W, 16, counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  single system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- raw0  input  1  asynchronous raw input, channel 0
- raw1  input  1  asynchronous raw input, channel 1
- in0  output  1  debounced level, channel 0; feeds AND operand in0
- in1  output  1  debounced level, channel 1; feeds AND operand in1
- rise0  output  1  one-cycle pulse when in0 goes 0->1
- fall0  output  1  one-cycle pulse when in0 goes 1->0
- rise1  output  1  one-cycle pulse when in1 goes 0->1
- fall1  output  1  one-cycle pulse when in1 goes 1->0

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-high, port rst.
- Reset (rst sampled high):
  - All synchronizer flops clear to 0.
  - Both FSMs go to STABLE_LO; both counters clear to 0.
  - in0, in1, rise0, fall0, rise1 and fall1 are all 0 on the next edge.
  - Reset mid-wait abandons the pending change; no pulse is emitted.
- Synchronizer:
  - rawN passes through SYNC_STAGES flops to give syncN.
  - No logic sits between the synchronizer flops.
- Per-channel FSM states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
  - STABLE_LO: if syncN=1, go to WAIT_HI with cnt=1; else stay with cnt=0.
  - WAIT_HI, syncN=0: return to STABLE_LO, cnt=0. This is a glitch reject; no output change and no pulse.
  - WAIT_HI, syncN=1 and cnt<DEBOUNCE_CYCLES: cnt increments.
  - WAIT_HI, syncN=1 and cnt==DEBOUNCE_CYCLES: go to STABLE_HI, inN<=1, riseN<=1 for exactly one cycle, cnt=0.
  - STABLE_HI and WAIT_LO mirror the above with the polarity inverted; acceptance sets inN<=0 and pulses fallN.
- Latency:
  - A clean step on rawN held steady reaches inN exactly SYNC_STAGES+DEBOUNCE_CYCLES edges after the first edge that samples the new level.
  - The pulse is asserted in the same cycle inN first shows the new value.
- Glitches:
  - Any excursion shorter than DEBOUNCE_CYCLES synchronized cycles never changes inN.
  - A glitch restarts qualification from cnt=1 on the next excursion.
- Counter: saturating behaviour is never needed, because the counter is compared for equality and cleared on every state change. It never exceeds DEBOUNCE_CYCLES.
- Outputs:
  - inN, riseN and fallN are registered; no combinational path from raw inputs.
  - riseN and fallN are never high simultaneously.
- Channels are fully independent:
  - Simultaneous transitions on raw0 and raw1 qualify in parallel.
  - With identical stimulus, both outputs change on the same edge.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4 unless stated):
- Reset check: hold rst for 3 cycles with raw0=raw1=1 -> all six outputs 0 during reset; in0 and in1 rise 6 edges after rst deasserts; rise0 and rise1 pulse once, in the same cycle.
- Clean step: raw0 0->1 held -> in0=1 exactly 6 edges after first sample; rise0 high for exactly 1 cycle; in1, rise1 and fall1 stay 0.
- Bounce rejection: raw0 toggles with a 3-cycle high / 1-cycle low pattern 5 times, then holds high -> in0 stays 0 through the bounce; it rises 6 edges after the final steady rise; exactly one rise0 pulse.
- Falling edge: in1=1 steady, raw1 1->0 held -> in1=0 after 6 edges; fall1 one-cycle pulse; no rise1.
- Reset mid-qualification: raw0 rises; assert rst 4 edges later for 1 cycle; keep raw0 high -> no rise0 during the abandoned wait; in0 rises 6 edges after rst drops.
- Independence plus downstream: raw0 and raw1 rise on the same edge -> in0 and in1 rise on the same edge, so the AND output goes 1 that cycle. Then raw1 falls -> AND output falls 6 edges later while in0 is unchanged.
